// File: rtl/cam_dvp_pkg.sv
// cam_dvp_pkg: shared types and constants for the DVP test-pattern transmitter
// Contents: FSM state enum, pattern codes, RGB565 bar colours, OV7670 VGA timing defaults.
package cam_dvp_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT} state_e;
  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  // Element 0 is the leftmost bar.
  localparam logic [7:0][15:0] BAR_COLORS = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                             RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_H_BLANK     = 144;
  localparam int VGA_VSYNC_LINES = 3;
  localparam int VGA_V_BACK      = 17;
  localparam int VGA_V_FRONT     = 10;
endpackage

// File: rtl/cam_dvp_pattern.sv
// cam_dvp_pattern: registered RGB565 test-pattern pixel generator
// Ports: i_clk/i_rst_n clock and async active-low reset; i_en loads the pixel register;
//        i_pattern/i_const select the pattern; i_x/i_y pixel position; o_pix registered pixel.
module cam_dvp_pattern import cam_dvp_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_const,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_pix
);
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0]  bar;
  logic        check;
  logic [15:0] pix_d, pix_q;
  // Bar index by threshold counting avoids a divider when the bar width is not a power of two.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) if (int'(i_x) >= k * BAR_W) bar = bar + 3'd1;
    check = |((i_x ^ i_y) & 16'h0008);
    pix_d = i_pattern == PAT_CONST ? i_const :
            i_pattern == PAT_BARS  ? BAR_COLORS[bar] :
            i_pattern == PAT_RAMP  ? {i_x[4:0], i_x[5:0], i_x[4:0]} :
            (check ? RGB_WHITE : RGB_BLACK);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pix_q <= '0;
    else if (i_en) pix_q <= pix_d;
  end
  assign o_pix = pix_q;
endmodule

// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: OV7670-style DVP transmitter emitting RGB565 test-pattern frames
// Ports: i_clk board clock; i_rst_n async active-low reset; i_run emit frames while high;
//        i_pattern 0 const/1 bars/2 ramp/3 checker; i_const pattern-0 colour;
//        o_pclk (i_clk/2), o_vsync, o_href, o_data (high byte first); o_busy frame in progress;
//        o_frame_done end-of-frame pulse; o_frame_cnt completed frames.
// Option: define CAM_DVP_TX_CHECKSUM_EN to add o_frame_sum, the 16-bit sum of the
//         active bytes of the last complete frame.
module cam_dvp_tx import cam_dvp_pkg::*; #(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int H_BLANK     = VGA_H_BLANK,
  parameter int VSYNC_LINES = VGA_VSYNC_LINES,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int V_FRONT     = VGA_V_FRONT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_const,
  output logic        o_pclk,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
`ifdef CAM_DVP_TX_CHECKSUM_EN
  ,
  output logic [15:0] o_frame_sum
`endif
);
  localparam int LINE_PIX  = H_ACTIVE + H_BLANK;
  localparam int LINE_CLKS = 4 * LINE_PIX;
  localparam int CW        = $clog2(LINE_CLKS);
  localparam logic [CW-1:0] LAST_CLK  = CW'(LINE_CLKS - 1);
  localparam logic [CW-1:0] HREF_CLKS = CW'(4 * H_ACTIVE);
  localparam logic [CW-3:0] LAST_PIX  = (CW-2)'(LINE_PIX - 1);
  localparam logic [15:0] L_VSYNC  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] L_BACK   = 16'(V_BACK - 1);
  localparam logic [15:0] L_ACTIVE = 16'(V_ACTIVE - 1);
  localparam logic [15:0] L_FRONT  = 16'(V_FRONT - 1);
  state_e        state_q, state_d;
  logic [CW-1:0] clk_q, clk_d;
  logic [15:0]   line_q, line_d, last_line, cnt_q;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   cst_q, cst_d, pix, x_in, y_in;
  logic [CW-3:0] px, nx;
  logic          line_end, last, enter, wrap, fetch;
  logic          pclk_q, pclk_d, vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]    data_q, data_d;
  // Output registers are loaded from the *next* position, so every output is aligned
  // with clk_q; clk_q[0] is the pclk phase and byte boundaries sit on even counts,
  // which makes data/href/vsync change only where pclk falls.
  always_comb begin
    state_d = state_q;
    line_d = line_q;
    line_end = clk_q == LAST_CLK;
    last_line = state_q == ST_VSYNC ? L_VSYNC :
                state_q == ST_VBACK ? L_BACK :
                state_q == ST_ACTIVE ? L_ACTIVE : L_FRONT;
    last = line_end && line_q == last_line;
    clk_d = (state_q == ST_IDLE || line_end) ? '0 : clk_q + CW'(1);
    if (state_q == ST_IDLE) begin
      state_d = i_run ? ST_VSYNC : ST_IDLE;
      line_d = '0;
    end else if (line_end) begin
      line_d = last ? '0 : line_q + 16'd1;
      if (last) begin
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          default:   state_d = i_run ? ST_VSYNC : ST_IDLE;
        endcase
      end
    end
    enter = state_d == ST_VSYNC && state_q != ST_VSYNC;
    pat_d = enter ? i_pattern : pat_q;
    cst_d = enter ? i_const : cst_q;
    pclk_d = state_d != ST_IDLE && clk_d[0];
    vsync_d = state_d == ST_VSYNC;
    href_d = state_d == ST_ACTIVE && clk_d < HREF_CLKS;
    data_d = href_d ? (clk_d[1] ? pix[7:0] : pix[15:8]) : '0;
    busy_d = state_d != ST_IDLE;
    done_d = state_q == ST_VFRONT && line_q == L_FRONT && clk_q == LAST_CLK - CW'(1);
  end
  // Prefetch: in the third clock of each pixel load the next pixel (wrapping into the
  // following line), so the register holds it exactly when its high byte goes out.
  always_comb begin
    px = clk_q[CW-1:2];
    wrap = px == LAST_PIX;
    nx = wrap ? '0 : px + (CW-2)'(1);
    x_in = 16'(nx);
    y_in = state_q == ST_ACTIVE ? line_q + 16'(wrap) : 16'd0;
    fetch = state_q != ST_IDLE && clk_q[1:0] == 2'd2;
  end
  cam_dvp_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (fetch),
    .i_pattern (pat_q),
    .i_const   (cst_q),
    .i_x       (x_in),
    .i_y       (y_in),
    .o_pix     (pix)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      clk_q <= '0;
      line_q <= '0;
      pat_q <= '0;
      cst_q <= '0;
      pclk_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clk_q <= clk_d;
      line_q <= line_d;
      pat_q <= pat_d;
      cst_q <= cst_d;
      pclk_q <= pclk_d;
      vsync_q <= vsync_d;
      href_q <= href_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q <= cnt_q + 16'(done_d);
    end
  end
`ifdef CAM_DVP_TX_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, sum_q;
  // Each byte is held for two clocks; count it once, on its first clock.
  assign acc_d = enter ? '0 : (href_d && !clk_d[0]) ? acc_q + 16'(data_d) : acc_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= done_d ? acc_q : sum_q;
    end
  end
  assign o_frame_sum = sum_q;
`endif
  assign o_pclk = pclk_q;
  assign o_vsync = vsync_q;
  assign o_href = href_q;
  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_frame_done = done_q;
  assign o_frame_cnt = cnt_q;
endmodule

// File: tb/tb_cam_dvp_tx.sv
// tb_cam_dvp_tx: scoreboard bench for cam_dvp_tx with a small 8x4 frame geometry
module tb_cam_dvp_tx;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic [15:0] cval = 16'h0;
  logic pclk, vsync, href, busy, done;
  logic [7:0] data;
  logic [15:0] fcnt;
`ifdef CAM_DVP_TX_CHECKSUM_EN
  logic [15:0] fsum;
`endif
  int n_vec = 0, n_err = 0, exp_cnt = 0, fcyc = 0, hcnt = 0;
  logic pp = 1'b0, ph = 1'b0, pv = 1'b0;
  logic [7:0] pd = 8'h0;
  logic [7:0] q[$];
  bit dropped;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                      16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  cam_dvp_tx #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_run        (run),
    .i_pattern    (pattern),
    .i_const      (cval),
    .o_pclk       (pclk),
    .o_vsync      (vsync),
    .o_href       (href),
    .o_data       (data),
    .o_busy       (busy),
    .o_frame_done (done),
    .o_frame_cnt  (fcnt)
`ifdef CAM_DVP_TX_CHECKSUM_EN
    ,
    .o_frame_sum  (fsum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] p, input logic [15:0] c, input int x, input int y);
    logic [15:0] xv;
    xv = 16'(x);
    case (p)
      2'd0: return c;
      2'd1: return BARS[x];
      2'd2: return {xv[4:0], xv[5:0], xv[4:0]};
      default: return (((x ^ y) & 8) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] p, input logic [15:0] c);
    logic [15:0] v;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        v = model(p, c, x, y);
        q.push_back(v[15:8]);
        q.push_back(v[7:0]);
      end
  endtask

  task automatic start(input logic [1:0] p, input logic [15:0] c, input bit keep);
    @(negedge clk);
    pattern = p;
    cval = c;
    run = 1'b1;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_vsync", vsync, 1);
    chk("start_pclk", pclk, 0);
    if (!keep) run = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    dropped = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) dropped = 1'b1;
    end while (!done && n < 400);
    chk({name, "_done"}, done, 1);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_pclk"}, pclk, 0);
    chk({name, "_vsync"}, vsync, 0);
  endtask

  // Monitor: byte scoreboard on rising pclk, plus framing checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt = 0;
      fcyc = 0;
      hcnt = 0;
      pp = 1'b0;
      ph = 1'b0;
      pv = 1'b0;
      pd = 8'h0;
    end else begin
      if (vsync && !pv) begin
        fcyc = 1;
        hcnt = 0;
      end else fcyc++;
      if (pclk && !pp) chk("stable_at_pclk_rise", {22'h0, vsync, href, data}, {22'h0, pv, ph, pd});
      if (!href) chk("data_zero_no_href", data, 0);
      if (href && !ph) begin
        chk("href_position", fcyc, 97 + 48 * hcnt);
        hcnt++;
      end
      if (href && pclk && !pp) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL byte: got %0h expected none (scoreboard empty)", data);
        end else chk("byte", data, q.pop_front());
      end
      if (done) begin
        exp_cnt++;
        chk("done_position", fcyc, 336);
        chk("frame_cnt_mon", fcnt, exp_cnt);
      end
      pp = pclk;
      ph = href;
      pv = vsync;
      pd = data;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_pclk", pclk, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", fcnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pclk", pclk, 0);

    push_frame(2'd0, 16'hA55A);
    start(2'd0, 16'hA55A, 1'b0);
    wait_done("const");
    chk("const_cnt", fcnt, 1);
    chk("const_queue", q.size(), 0);
    check_idle("const_idle");

    push_frame(2'd1, 16'h0000);
    start(2'd1, 16'h0000, 1'b0);
    wait_done("bars");
    chk("bars_queue", q.size(), 0);
    check_idle("bars_idle");

    push_frame(2'd2, 16'h0000);
    start(2'd2, 16'h0000, 1'b0);
    wait_done("ramp");
    chk("ramp_queue", q.size(), 0);

    push_frame(2'd3, 16'h0000);
    start(2'd3, 16'h0000, 1'b0);
    wait_done("checker");
    chk("checker_cnt", fcnt, 4);
    chk("checker_queue", q.size(), 0);

    for (int f = 0; f < 3; f++) push_frame(2'd0, 16'h1234);
    start(2'd0, 16'h1234, 1'b1);
    wait_done("b2b1");
    chk("b2b1_busy_held", dropped, 0);
    @(negedge clk);
    chk("b2b1_vsync", vsync, 1);
    chk("b2b1_busy", busy, 1);
    wait_done("b2b2");
    chk("b2b2_busy_held", dropped, 0);
    @(negedge clk);
    chk("b2b2_vsync", vsync, 1);
    run = 1'b0;
    wait_done("b2b3");
    chk("b2b3_busy_held", dropped, 0);
    chk("b2b_cnt", fcnt, 7);
    chk("b2b_queue", q.size(), 0);
    check_idle("b2b_idle");

    push_frame(2'd1, 16'h0000);
    start(2'd1, 16'h0000, 1'b1);
    repeat (150) @(negedge clk);
    run = 1'b0;
    pattern = 2'd3;
    cval = 16'hFFFF;
    wait_done("drop");
    chk("drop_cnt", fcnt, 8);
    chk("drop_queue", q.size(), 0);
    check_idle("drop_idle");
    repeat (5) @(negedge clk);
    chk("drop_pclk_held", pclk, 0);

    push_frame(2'd0, 16'h0F0F);
    start(2'd0, 16'h0F0F, 1'b0);
    n = 0;
    while (!href && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_href_seen", href, 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_pclk", pclk, 0);
    chk("rstmid_vsync", vsync, 0);
    chk("rstmid_href", href, 0);
    chk("rstmid_data", data, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_cnt", fcnt, 0);
    q.delete();
    repeat (5) begin
      @(negedge clk);
      chk("rstmid_no_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    push_frame(2'd0, 16'h0102);
    start(2'd0, 16'h0102, 1'b0);
    wait_done("sum");
    chk("post_rst_cnt", fcnt, 1);
`ifdef CAM_DVP_TX_CHECKSUM_EN
    chk("frame_sum", fsum, 96);
`endif
    chk("sum_queue", q.size(), 0);
    check_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cam_dvp_tx.md
# cam_dvp_tx

Synthesizable OV7670-style DVP camera transmitter: generates PCLK/VSYNC/HREF/8-bit DATA frames of RGB565 test patterns, driving the camera-side interface of the capture path. Used for on-board loopback when no sensor is fitted and as the stimulus source for capture, Gaussian/Sobel and VGA verification. Sits in the board-clock domain; its outputs connect directly to the capture block's pclk/vsync/href/data inputs.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 144, blank pixel periods per line (HREF low)
- VSYNC_LINES, 3, lines with VSYNC high
- V_BACK, 17, lines after VSYNC before first active line
- V_FRONT, 10, lines after last active line
- i_clk  in  1  board clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_run  in  1  level; high = emit frames back to back
- i_pattern  in  2  0 constant, 1 colour bars, 2 ramp, 3 checkerboard
- i_const  in  16  RGB565 value for pattern 0
- o_pclk  out  1  generated pixel clock, i_clk/2
- o_vsync  out  1  frame sync, active high
- o_href  out  1  line valid, active high
- o_data  out  8  byte, high byte of each RGB565 pixel first
- o_busy  out  1  high from frame start to frame end
- o_frame_done  out  1  one-cycle pulse at end of each frame
- o_frame_cnt  out  16  completed frames, wraps 0xFFFF->0

## Operation
- FSM: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. IDLE->VSYNC when i_run=1; VSYNC->VBACK after VSYNC_LINES lines; VBACK->ACTIVE after V_BACK; ACTIVE->VFRONT after V_ACTIVE; VFRONT->VSYNC if i_run=1 else IDLE.
- Line = (H_ACTIVE+H_BLANK) pixel periods; pixel = 2 bytes; byte = 2 clocks; line = 4*(H_ACTIVE+H_BLANK) clocks.
- HREF high for first H_ACTIVE pixel periods of each ACTIVE line only; o_data = 0 whenever o_href=0.
- i_pattern and i_const sampled on entry to VSYNC; mid-frame changes ignored.
- Patterns (x column, y active row): 1 = 8 bars of H_ACTIVE/8 columns, order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000; 2 = {x[4:0], x[5:0], x[4:0]}; 3 = (x[3]^y[3]) ? FFFF : 0000.
- i_run falling mid-frame: current frame completes, then IDLE.
- o_frame_cnt increments in the same cycle o_frame_done pulses.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0; reset mid-frame aborts immediately, no partial frame_done.
- o_pclk toggles every clock while not IDLE, held 0 in IDLE.
- o_vsync/o_href/o_data change only on the clock where o_pclk goes 1->0; stable across each rising o_pclk edge.
- i_run=1 sampled in IDLE -> next clock o_busy=1, o_vsync=1, o_pclk=0.
- First active byte appears (VSYNC_LINES+V_BACK) line periods after o_vsync rise.
- o_frame_done on last clock of VFRONT; o_busy drops next clock if going IDLE, stays high if continuing.

## Configuration
- CAM_DVP_TX_CHECKSUM_EN defined: adds output o_frame_sum (16 bits) = modulo-2^16 sum of all active bytes of the last complete frame, updated with o_frame_done, reset 0. Undefined: port and adder absent; behaviour otherwise identical.

## Structure
- Package cam_dvp_pkg: FSM state enum, pattern code constants, RGB565 bar colour constants, OV7670 VGA default timing constants.
- Sub-module cam_dvp_pattern: (pattern, const, x, y) -> 16-bit pixel, registered once, fed one pixel ahead.

## Test plan
Bench params H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (line 48 clocks, frame 336 clocks).
- Reset then i_run=1 one frame, pattern 0, i_const=0xA55A -> 4 lines of 8 pixels, bytes A5,5A repeated; 16 bytes per HREF; frame_done at clock 336; frame_cnt=1.
- Pattern 1 -> byte pairs per pixel FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
- Pattern 3, row 0 -> all bytes 00 (x<8); sampling on rising o_pclk, data never changes at rising edges.
- i_run held high 3 frames -> VSYNC re-asserts immediately after frame_done, o_busy never drops, frame_cnt=3.
- i_run dropped mid-frame and pattern changed mid-frame -> frame completes with original pattern, IDLE, o_pclk=0.
- i_rst_n low mid-ACTIVE -> all outputs 0 same cycle, no frame_done; with CAM_DVP_TX_CHECKSUM_EN, pattern 0 0x0102 -> o_frame_sum=96.
